if_stage: RTL

- Instruction-fetch stage. Sits directly upstream of the decode stage and feeds it `pc_if`, `instruction`, `instruction_value` and `is_compress_intr`.
- Runs a sequential PC and a req/gnt/rvalid instruction-bus handshake.
- Buffers returned words in a small prefetch FIFO and tags each word with its PC.
- Handles taken-branch/jump redirects from execute, discarding any stale in-flight responses.

---
 rtl/if_pkg.sv | 17 +
 rtl/if_prefetch_fifo.sv | 58 +++++
 rtl/if_stage.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_REDIR = 2'd2
  } if_state_e;

  localparam logic [31:0] IF_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_entry_t;

endpackage

// File: rtl/if_prefetch_fifo.sv
// Prefetch FIFO holding {pc, instr} entries. Clear beats push/pop.
// DEPTH must be a power of two >= 2.
module if_prefetch_fifo
  import if_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  if_entry_t              i_wdata,
  input  logic                   i_pop,
  input  logic                   i_clear,
  output if_entry_t              o_rdata,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty,
  output logic                   o_full
);

  localparam int unsigned AW = $clog2(DEPTH);

  if_entry_t     r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (w_do_push && !i_clear) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end

  // The fetch stage never requests more than the FIFO can absorb.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
    !(i_push && o_full && !i_pop && !i_clear));

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: sequential PC, req/gnt/rvalid bus, prefetch FIFO,
// branch redirect with discard of stale in-flight responses.
// Optional: IF_MISALIGN_CHK_EN adds fetch_misalign and halts fetch on a
// misaligned redirect target; otherwise target[1:0] is ignored.
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        instr_req,
  output logic [31:0] instr_addr,
  input  logic        instr_gnt,
  input  logic        instr_rvalid,
  input  logic [31:0] instr_rdata,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  input  logic        id_stage_ready,
  output logic [31:0] pc_if,
  output logic [31:0] instruction,
  output logic        instruction_value,
  output logic        is_compress_intr
`ifdef IF_MISALIGN_CHK_EN
  ,
  output logic        fetch_misalign
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  if_state_e   r_state;
  logic        r_req;
  logic [31:0] r_addr;
  logic [31:0] r_redir_tgt;
  logic [31:0] r_rsp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;

  logic        w_gnt_fire;
  logic        w_drop;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_target;
  logic [CW-1:0] w_out_next;
  logic [CW-1:0] w_cnt_next;
  logic        w_can_req;
  logic        w_halt_next;

  if_entry_t   w_wdata;
  if_entry_t   w_head;
  logic [CW-1:0] w_fifo_count;
  logic        w_fifo_empty;
  logic        w_fifo_full;

  assign w_gnt_fire = r_req && instr_gnt;
  assign w_drop     = instr_rvalid && (r_discard != '0);
  assign w_push     = instr_rvalid && (r_discard == '0) && !branch_valid;
  assign w_pop      = instruction_value && id_stage_ready;
  assign w_target   = branch_target & ~32'h0000_0003;

  // Lookahead of in-flight and buffered words after this edge.
  assign w_out_next = r_outstanding + CW'(w_gnt_fire) - CW'(instr_rvalid);
  assign w_cnt_next = branch_valid ? '0
                    : (w_fifo_count + CW'(w_push) - CW'(w_pop));
  assign w_can_req  = (({1'b0, w_out_next} + {1'b0, w_cnt_next}) < DEPTH_W)
                    && !w_halt_next;

  assign w_wdata.pc    = r_rsp_pc;
  assign w_wdata.instr = instr_rdata;

  if_prefetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .i_clear (branch_valid),
    .o_rdata (w_head),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  assign instr_req         = r_req;
  assign instr_addr        = r_addr;
  assign instruction_value = !w_fifo_empty && !branch_valid;
  assign pc_if             = w_fifo_empty ? '0 : w_head.pc;
  assign instruction       = w_fifo_empty ? IF_NOP : w_head.instr;
  assign is_compress_intr  = 1'b0;

`ifdef IF_MISALIGN_CHK_EN
  logic w_misalign;
  logic r_halt;
  logic r_misalign;

  assign w_misalign     = (branch_target[1:0] != 2'b00);
  assign w_halt_next    = branch_valid ? w_misalign : r_halt;
  assign fetch_misalign = r_misalign;

  // Halt latches on a misaligned redirect and clears on the next aligned one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_halt     <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_halt     <= w_halt_next;
      r_misalign <= branch_valid && w_misalign;
    end
  end
`else
  assign w_halt_next = 1'b0;
`endif

  // Fetch FSM, bus request and response bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_req         <= 1'b0;
      r_addr        <= BOOT_ADDR;
      r_redir_tgt   <= BOOT_ADDR;
      r_rsp_pc      <= BOOT_ADDR;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= w_out_next;

      // Everything still in flight after a redirect is stale, including a
      // request granted in the redirect cycle; a request parked in REDIR is
      // added when it is finally granted.
      if (branch_valid) begin
        r_discard <= w_out_next;
      end else if (r_state == ST_REDIR && w_gnt_fire) begin
        r_discard <= r_discard - CW'(w_drop) + CW'(1'b1);
      end else begin
        r_discard <= r_discard - CW'(w_drop);
      end

      // Responses return in grant order, so the PC of the next kept word is
      // the redirect target advanced by one word per push.
      if (branch_valid) begin
        r_rsp_pc <= w_target;
      end else if (w_push) begin
        r_rsp_pc <= r_rsp_pc + 32'd4;
      end

      if (branch_valid) begin
        if (r_req && !instr_gnt) begin
          r_state     <= ST_REDIR;
          r_redir_tgt <= w_target;
        end else begin
          r_state <= ST_FETCH;
          r_addr  <= w_target;
          r_req   <= w_can_req;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_FETCH;
            r_req   <= 1'b0;
          end
          ST_FETCH: begin
            if (!(r_req && !instr_gnt)) begin
              if (w_gnt_fire) r_addr <= r_addr + 32'd4;
              r_req <= w_can_req;
            end
          end
          ST_REDIR: begin
            if (w_gnt_fire) begin
              r_addr  <= r_redir_tgt;
              r_state <= ST_FETCH;
              r_req   <= w_can_req;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
